// File: rtl/encoder_seg_display_pkg.sv
// Shared definitions for the encoder position display: converter states,
// active-low seven-segment patterns (gfedcba) and digit-select indices.
package encoder_seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] SEL_UNITS     = 2'd0;
  localparam logic [1:0] SEL_TENS      = 2'd1;
  localparam logic [1:0] SEL_HUNDREDS  = 2'd2;
  localparam logic [1:0] SEL_THOUSANDS = 2'd3;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/encoder_seg_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// DATA_W iterations, then a one-cycle done pulse with the 3-digit result.
module bin2bcd_seq
  import encoder_seg_display_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] bin_in,
  output logic              busy,
  output logic              done,
  output logic [11:0]       bcd_out
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  conv_state_e       state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [11:0]       bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        busy           = 1'b1;
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bcd_out = bcd_q;

endmodule

// File: rtl/encoder_seg_display.sv
// Encoder position display: restarts a BCD conversion whenever the position
// changes and multiplexes the digits onto a 4-digit active-low display.
module encoder_seg_display
  import encoder_seg_display_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int REFRESH_BITS = 18,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] value8,
  output logic              busy,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              dp
);

  logic                    first_q, first_d;
  logic [DATA_W-1:0]       last_q, last_d;
  logic [11:0]             disp_q, disp_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    start, conv_done;
  logic [11:0]             conv_bcd;
  logic [1:0]              sel;
  logic [3:0]              hundreds, tens, units;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bin_in (value8),
    .busy   (busy),
    .done   (conv_done),
    .bcd_out(conv_bcd)
  );

  // A change that arrives mid-conversion is picked up once the engine is idle again.
  assign start = !busy && (first_q || (value8 != last_q));

  assign sel      = refresh_q[REFRESH_BITS-1 -: 2];
  assign hundreds = disp_q[11:8];
  assign tens     = disp_q[7:4];
  assign units    = disp_q[3:0];

  always_comb begin
    first_d   = first_q;
    last_d    = last_q;
    disp_d    = conv_done ? conv_bcd : disp_q;
    refresh_d = refresh_q + REFRESH_BITS'(1);
    an_d      = 4'b1111;
    seg_d     = SEG_BLANK;
    if (start) begin
      first_d = 1'b0;
      last_d  = value8;
    end
    case (sel)
      SEL_UNITS: begin
        an_d  = 4'b1110;
        seg_d = seg_decode(units);
      end
      SEL_TENS: begin
        an_d  = 4'b1101;
        seg_d = (LZ_BLANK && hundreds == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_decode(tens);
      end
      SEL_HUNDREDS: begin
        an_d  = 4'b1011;
        seg_d = (LZ_BLANK && hundreds == 4'd0) ? SEG_BLANK : seg_decode(hundreds);
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q   <= 1'b1;
      last_q    <= '0;
      disp_q    <= '0;
      refresh_q <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      first_q   <= first_d;
      last_q    <= last_d;
      disp_q    <= disp_d;
      refresh_q <= refresh_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule
